video_mode_scheduler: RTL and testbench



---
 rtl/video_mode_scheduler.sv | 161 ++++++++++++++++
 tb/tb_video_mode_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : video_mode_scheduler
// Purpose  : Frame line-count measurement, debounced scaler slot selection and
//            once-per-frame slot-word injection on a 1-cycle video pass-through.
// Revision : 1.0
// ============================================================================
module video_mode_scheduler #(
    parameter int         SLOT_COUNT               = 2,
    parameter logic [8:0] SLOT_LINES [SLOT_COUNT]  = '{9'd224, 9'd239},
    parameter int         STABLE_FRAMES            = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        de_in,
    input  logic [23:0] rgb_in,
    output logic        vsync,
    output logic        hsync,
    output logic        de,
    output logic [23:0] rgb,
    output logic [2:0]  active_slot,
    output logic [8:0]  lines_measured,
    output logic        locked
);

    localparam logic [0:0] c_wait_vsync    = 1'b0;
    localparam logic [0:0] c_measure       = 1'b1;
    localparam logic [3:0] c_stable_thresh = 4'(STABLE_FRAMES);
    localparam logic [3:0] c_stable_max    = 4'd15;
    localparam logic [8:0] c_line_max      = 9'd511;

    logic [0:0]  state_q, state_d;
    logic        vsync_q, hsync_q, de_q;
    logic [23:0] rgb_q, rgb_d;
    logic [8:0]  line_cnt_q, line_cnt_d;
    logic [8:0]  lines_measured_q, lines_measured_d;
    logic [2:0]  cand_q, cand_d;
    logic [3:0]  stable_cnt_q, stable_cnt_d;
    logic [2:0]  active_slot_q, active_slot_d;
    logic        locked_q, locked_d;
    logic        armed_q, armed_d;

    logic        w_de_fall;
    logic        w_measuring;
    logic [2:0]  w_sel;

    // de_q doubles as the previous-cycle de_in, so it also drives edge detection.
    assign w_de_fall   = de_q & ~de_in;
    assign w_measuring = (state_q == c_measure);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_wait_vsync;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if ((state_q == c_wait_vsync) && vsync_in) begin
            state_d = c_measure;
        end
    end

    // Smallest slot whose limit covers the count; the last slot catches the rest.
    always_comb begin
        w_sel = 3'(SLOT_COUNT - 1);
        for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
            if (line_cnt_q <= SLOT_LINES[i]) begin
                w_sel = 3'(i);
            end
        end
    end

    // Output / datapath logic
    always_comb begin
        line_cnt_d       = line_cnt_q;
        lines_measured_d = lines_measured_q;
        cand_d           = cand_q;
        stable_cnt_d     = stable_cnt_q;
        active_slot_d    = active_slot_q;
        locked_d         = locked_q;
        armed_d          = armed_q;
        rgb_d            = rgb_in;

        if (vsync_in) begin
            line_cnt_d = '0;
            if (w_measuring) begin
                armed_d          = 1'b1;
                lines_measured_d = line_cnt_q;
                if (line_cnt_q != '0) begin
                    if (w_sel == cand_q) begin
                        stable_cnt_d = (stable_cnt_q == c_stable_max) ? stable_cnt_q
                                                                      : stable_cnt_q + 4'd1;
                    end else begin
                        cand_d       = w_sel;
                        stable_cnt_d = 4'd1;
                    end
                    if (stable_cnt_d >= c_stable_thresh) begin
                        active_slot_d = cand_d;
                        locked_d      = 1'b1;
                    end else if (w_sel != active_slot_q) begin
                        locked_d = 1'b0;
                    end
                end
            end
        end else if (w_de_fall && w_measuring) begin
            if (line_cnt_q != c_line_max) begin
                line_cnt_d = line_cnt_q + 9'd1;
            end
            // The slot word replaces the blanking pixel that follows the first active line.
            if (armed_q) begin
                rgb_d   = {21'd0, active_slot_q};
                armed_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q          <= 1'b0;
            hsync_q          <= 1'b0;
            de_q             <= 1'b0;
            rgb_q            <= '0;
            line_cnt_q       <= '0;
            lines_measured_q <= '0;
            cand_q           <= '0;
            stable_cnt_q     <= '0;
            active_slot_q    <= '0;
            locked_q         <= 1'b0;
            armed_q          <= 1'b0;
        end else begin
            vsync_q          <= vsync_in;
            hsync_q          <= hsync_in;
            de_q             <= de_in;
            rgb_q            <= rgb_d;
            line_cnt_q       <= line_cnt_d;
            lines_measured_q <= lines_measured_d;
            cand_q           <= cand_d;
            stable_cnt_q     <= stable_cnt_d;
            active_slot_q    <= active_slot_d;
            locked_q         <= locked_d;
            armed_q          <= armed_d;
        end
    end

    assign vsync          = vsync_q;
    assign hsync          = hsync_q;
    assign de             = de_q;
    assign rgb            = rgb_q;
    assign active_slot    = active_slot_q;
    assign lines_measured = lines_measured_q;
    assign locked         = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_video_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_mode_scheduler
// Purpose  : Directed + randomized frame stream against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_video_mode_scheduler;

    localparam int SLOT_COUNT    = 2;
    localparam int STABLE_FRAMES = 4;
    localparam int LIMITS [2]    = '{224, 239};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_in = 1'b0, hsync_in = 1'b0, de_in = 1'b0;
    logic [23:0] rgb_in = '0;
    logic        vsync, hsync, de, locked;
    logic [23:0] rgb;
    logic [2:0]  active_slot;
    logic [8:0]  lines_measured;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_measuring, m_armed, m_prev_de, m_locked;
    int          m_cnt, m_lines, m_active;
    int          hist[$];
    logic        e_vs, e_hs, e_de;
    logic [23:0] e_rgb;

    video_mode_scheduler #(
        .SLOT_COUNT    (SLOT_COUNT),
        .STABLE_FRAMES (STABLE_FRAMES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .vsync_in       (vsync_in),
        .hsync_in       (hsync_in),
        .de_in          (de_in),
        .rgb_in         (rgb_in),
        .vsync          (vsync),
        .hsync          (hsync),
        .de             (de),
        .rgb            (rgb),
        .active_slot    (active_slot),
        .lines_measured (lines_measured),
        .locked         (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_sel(input int n);
        for (int i = 0; i < SLOT_COUNT; i++) begin
            if (n <= LIMITS[i]) return i;
        end
        return SLOT_COUNT - 1;
    endfunction

    // Length of the run of identical selections at the end of the history.
    function automatic int trailing_run();
        int run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size() - 1]) break;
            run++;
        end
        return (run > 15) ? 15 : run;
    endfunction

    task automatic evaluate(input int n);
        int s;
        m_lines = n;
        if (n != 0) begin
            s = ref_sel(n);
            hist.push_back(s);
            if (trailing_run() >= STABLE_FRAMES) begin
                m_active = s;
                m_locked = 1'b1;
            end else if (s != m_active) begin
                m_locked = 1'b0;
            end
        end
    endtask

    task automatic step(input logic vs, input logic hs, input logic d,
                        input logic [23:0] px, input logic rst);
        bit fall;
        vsync_in = vs; hsync_in = hs; de_in = d; rgb_in = px; reset = rst;
        @(posedge clk);
        #1;
        fall = m_prev_de && !d;
        if (rst) begin
            e_vs = 0; e_hs = 0; e_de = 0; e_rgb = '0;
            m_measuring = 0; m_armed = 0; m_prev_de = 0; m_locked = 0;
            m_cnt = 0; m_lines = 0; m_active = 0;
            hist.delete();
        end else begin
            e_vs = vs; e_hs = hs; e_de = d; e_rgb = px;
            if (vs) begin
                if (m_measuring) begin
                    evaluate(m_cnt);
                    m_armed = 1'b1;
                end
                m_measuring = 1'b1;
                m_cnt = 0;
            end else if (fall && m_measuring) begin
                m_cnt = (m_cnt + 1 > 511) ? 511 : m_cnt + 1;
                if (m_armed) begin
                    e_rgb   = {21'd0, 3'(m_active)};
                    m_armed = 1'b0;
                end
            end
            m_prev_de = d;
        end
        check("vsync", 32'(vsync), 32'(e_vs));
        check("hsync", 32'(hsync), 32'(e_hs));
        check("de", 32'(de), 32'(e_de));
        check("rgb", 32'(rgb), 32'(e_rgb));
        check("lines_measured", 32'(lines_measured), 32'(m_lines));
        check("active_slot", 32'(active_slot), 32'(m_active));
        check("locked", 32'(locked), 32'(m_locked));
    endtask

    // One frame: vsync cycle, n lines of two active pixels plus one blank, then tail.
    // open_end drops the last blank so that line's falling edge lands on the next vsync.
    task automatic frame(input int n, input bit open_end, input int tail);
        step(1'b1, 1'($urandom), 1'b0, 24'($urandom), 1'b0);
        for (int l = 0; l < n; l++) begin
            step(1'b0, 1'b0, 1'b1, 24'($urandom), 1'b0);
            step(1'b0, 1'b0, 1'b1, 24'($urandom), 1'b0);
            if (!(open_end && l == n - 1))
                step(1'b0, 1'($urandom), 1'b0, 24'($urandom), 1'b0);
        end
        for (int t = 0; t < tail; t++)
            step(1'b0, 1'($urandom), 1'b0, 24'($urandom), 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 24'hABCDEF, 1'b1);
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_locked", 32'(locked), 32'h0);

        // Lock on 224-line frames: evaluations start at the second vsync.
        for (int f = 0; f < 6; f++) frame(224, 1'b0, 2);
        check("lock224_locked", 32'(locked), 32'h1);
        check("lock224_slot", 32'(active_slot), 32'h0);
        check("lock224_lines", 32'(lines_measured), 32'd224);

        // Switch to 239 lines: three evaluations unlocked, the fourth relocks on slot 1.
        frame(239, 1'b0, 2);
        frame(239, 1'b0, 2);
        check("sw239_eval1_locked", 32'(locked), 32'h0);
        frame(239, 1'b0, 2);
        frame(239, 1'b0, 2);
        check("sw239_eval3_locked", 32'(locked), 32'h0);
        check("sw239_eval3_slot", 32'(active_slot), 32'h0);
        frame(239, 1'b0, 2);
        check("sw239_eval4_locked", 32'(locked), 32'h1);
        check("sw239_eval4_slot", 32'(active_slot), 32'h1);

        // Alternating frame sizes never build a run.
        for (int f = 0; f < 3; f++) begin
            frame(224, 1'b0, 2);
            frame(239, 1'b0, 2);
        end
        check("alt_slot", 32'(active_slot), 32'h1);
        check("alt_locked", 32'(locked), 32'h0);

        // Oversize and saturating frames, vsync coinciding with a de fall, empty frame.
        frame(300, 1'b0, 2);
        frame(600, 1'b0, 2);
        check("lines300", 32'(lines_measured), 32'd300);
        frame(10, 1'b1, 0);
        check("lines600_sat", 32'(lines_measured), 32'd511);
        frame(5, 1'b0, 2);
        check("vsync_fall_uncounted", 32'(lines_measured), 32'd9);
        frame(0, 1'b0, 3);
        frame(20, 1'b0, 2);
        check("empty_frame_lines", 32'(lines_measured), 32'd0);

        // Reset mid-frame: first vsync afterwards is not evaluated.
        step(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
        for (int l = 0; l < 100; l++) begin
            step(1'b0, 1'b0, 1'b1, 24'($urandom), 1'b0);
            step(1'b0, 1'b0, 1'b1, 24'($urandom), 1'b0);
            step(1'b0, 1'b1, 1'b0, 24'($urandom), 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 24'hFFFFFF, 1'b1);
        check("midreset_rgb", 32'(rgb), 32'h0);
        check("midreset_lines", 32'(lines_measured), 32'h0);
        frame(50, 1'b0, 2);
        check("post_reset_first_vsync_lines", 32'(lines_measured), 32'd0);
        frame(60, 1'b0, 2);
        check("post_reset_lines", 32'(lines_measured), 32'd50);
        check("post_reset_locked", 32'(locked), 32'h0);
        check("post_reset_slot", 32'(active_slot), 32'h0);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            bit open;
            open = 1'($urandom_range(0, 1));
            frame($urandom_range(1, 260), open, open ? 0 : $urandom_range(1, 3));
        end
        step(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
